// File: rtl/msdap_pkg.sv
// Shared types and constants for the MSDAP output capture path.
package msdap_pkg;

    localparam int MSDAP_OUT_W = 40;

    typedef enum logic {COL_IDLE, COL_SHIFT} col_state_t;

    typedef struct packed {
        logic [39:0] l;
        logic [39:0] r;
    } out_pair_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; the head is read straight from storage and forced to 0 when empty.
module sync_fifo
    import msdap_pkg::*;
#(
    parameter int W     = 2 * MSDAP_OUT_W,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign push_ok = push && (!full || pop_ok);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/msdap_output_collector.sv
// Deserialises the MSDAP OutputL/OutputR streams framed by OutReady into a
// FIFO of left/right word pairs, with overflow / truncation reporting.
module msdap_output_collector
    import msdap_pkg::*;
#(
    parameter int WORD_W = MSDAP_OUT_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                         SCLK,
    input  logic                         Reset_n,
    input  logic                         flush,
    input  logic                         OutReady,
    input  logic                         OutputL,
    input  logic                         OutputR,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WORD_W-1:0]            out_data_l,
    output logic [WORD_W-1:0]            out_data_r,
    output logic [$clog2(DEPTH+1)-1:0]   fill_level,
    output logic                         overflow,
    output logic                         short_word,
    output logic [CNT_W-1:0]             dropped_count
);

    localparam logic [5:0] LAST_BIT = 6'(WORD_W - 1);

    col_state_t              state;
    logic [5:0]              bit_cnt;
    logic [WORD_W-2:0]       shift_l;
    logic [WORD_W-2:0]       shift_r;
    logic                    word_done;
    logic                    short_evt;
    logic                    pop;
    logic                    push_blocked;
    logic                    full;
    logic                    empty;
    logic [2*WORD_W-1:0]     fifo_din;
    logic [2*WORD_W-1:0]     fifo_dout;

    // The final bit goes straight into the FIFO word, not through the shifter.
    assign word_done    = (state == COL_SHIFT) && OutReady && (bit_cnt == LAST_BIT);
    assign short_evt    = (state == COL_SHIFT) && !OutReady;
    assign pop          = out_valid && out_ready;
    assign push_blocked = word_done && full && !pop;
    assign fifo_din     = {shift_l, OutputL, shift_r, OutputR};
    assign out_valid    = !empty;
    assign {out_data_l, out_data_r} = fifo_dout;

    always_ff @(posedge SCLK) begin
        if (!Reset_n || flush) begin
            state         <= COL_IDLE;
            bit_cnt       <= '0;
            shift_l       <= '0;
            shift_r       <= '0;
            overflow      <= 1'b0;
            short_word    <= 1'b0;
            dropped_count <= '0;
        end else begin
            case (state)
                COL_IDLE: begin
                    if (OutReady) begin
                        shift_l <= {{(WORD_W-2){1'b0}}, OutputL};
                        shift_r <= {{(WORD_W-2){1'b0}}, OutputR};
                        bit_cnt <= 6'd1;
                        state   <= COL_SHIFT;
                    end
                end
                COL_SHIFT: begin
                    if (!OutReady) begin
                        shift_l    <= '0;
                        shift_r    <= '0;
                        bit_cnt    <= '0;
                        short_word <= 1'b1;
                        state      <= COL_IDLE;
                    end else if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        state   <= COL_IDLE;
                    end else begin
                        shift_l <= {shift_l[WORD_W-3:0], OutputL};
                        shift_r <= {shift_r[WORD_W-3:0], OutputR};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: state <= COL_IDLE;
            endcase

            if (push_blocked) overflow <= 1'b1;
            if ((short_evt || push_blocked) && (dropped_count != '1))
                dropped_count <= dropped_count + 1'b1;
        end
    end

    sync_fifo #(
        .W     (2 * WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (SCLK),
        .rst_n (Reset_n),
        .flush (flush),
        .push  (word_done),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (fill_level)
    );

endmodule

// File: tb/tb_msdap_output_collector.sv
// Randomised bench: bit-level reference model feeds a scoreboard that a monitor drains on each pop.
module tb_msdap_output_collector;
    import msdap_pkg::*;

    localparam int W     = MSDAP_OUT_W;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             SCLK = 1'b0;
    logic             Reset_n = 1'b0;
    logic             flush = 1'b0;
    logic             OutReady = 1'b0;
    logic             OutputL = 1'b0;
    logic             OutputR = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [W-1:0]     out_data_l;
    logic [W-1:0]     out_data_r;
    logic [2:0]       fill_level;
    logic             overflow;
    logic             short_word;
    logic [CNT_W-1:0] dropped_count;

    int total = 0;
    int bad   = 0;
    int rdy_mode = 0;   // 0: out_ready low, 1: high, 2: random

    always #5 SCLK = ~SCLK;

    msdap_output_collector #(.WORD_W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .SCLK          (SCLK),
        .Reset_n       (Reset_n),
        .flush         (flush),
        .OutReady      (OutReady),
        .OutputL       (OutputL),
        .OutputR       (OutputR),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data_l    (out_data_l),
        .out_data_r    (out_data_r),
        .fill_level    (fill_level),
        .overflow      (overflow),
        .short_word    (short_word),
        .dropped_count (dropped_count)
    );

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word is W consecutive OutReady-high samples; a run
    // that ends early is a short word. FIFO tracked as an occupancy count.
    int        occ = 0;
    int        nb = 0;
    int        m_drop = 0;
    bit        m_ovf = 1'b0;
    bit        m_short = 1'b0;
    logic [W-1:0] acc_l = '0;
    logic [W-1:0] acc_r = '0;
    out_pair_t exp_q[$];
    out_pair_t new_p;

    initial forever begin
        @(posedge SCLK);
        if (!Reset_n || flush) begin
            occ = 0; nb = 0; m_drop = 0; m_ovf = 1'b0; m_short = 1'b0;
            exp_q.delete();
        end else begin
            if (occ > 0 && out_ready) occ--;
            if (OutReady) begin
                acc_l[W-1-nb] = OutputL;
                acc_r[W-1-nb] = OutputR;
                nb++;
                if (nb == W) begin
                    nb = 0;
                    if (occ < DEPTH) begin
                        occ++;
                        new_p.l = acc_l;
                        new_p.r = acc_r;
                        exp_q.push_back(new_p);
                    end else begin
                        m_ovf = 1'b1;
                        if (m_drop < SAT) m_drop++;
                    end
                end
            end else if (nb > 0) begin
                nb = 0;
                m_short = 1'b1;
                if (m_drop < SAT) m_drop++;
            end
        end
    end

    // Monitor: status every cycle, data on every pop the DUT presents.
    out_pair_t mon_p;
    initial forever begin
        @(negedge SCLK);
        #1;
        chk("fill_level", 80'(fill_level), 80'(occ));
        chk("out_valid", 80'(out_valid), 80'(occ > 0));
        chk("overflow", 80'(overflow), 80'(m_ovf));
        chk("short_word", 80'(short_word), 80'(m_short));
        chk("dropped_count", 80'(dropped_count), 80'(m_drop));
        if (occ == 0) chk("empty_data", {out_data_l, out_data_r}, 80'(0));
        if (Reset_n && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got l=%h r=%h expected no word", out_data_l, out_data_r);
            end else begin
                mon_p = exp_q.pop_front();
                chk("pop_l", 80'(out_data_l), 80'(mon_p.l));
                chk("pop_r", 80'(out_data_r), 80'(mon_p.r));
            end
        end
    end

    function automatic logic [W-1:0] rnd();
        return W'({$urandom(), $urandom()});
    endfunction

    task automatic drive(input logic ordy, input logic l, input logic r);
        @(negedge SCLK);
        OutReady  = ordy;
        OutputL   = l;
        OutputR   = r;
        out_ready = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 1) == 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [W-1:0] l, input logic [W-1:0] r,
                             input int nbits, input bit rdy_last);
        for (int k = 0; k < nbits; k++) begin
            drive(1'b1, l[W-1-k], r[W-1-k]);
            if (rdy_last && k == W-1) out_ready = 1'b1;
        end
    endtask

    initial begin
        // reset held two cycles while OutReady toggles
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        Reset_n = 1'b1;
        idle(2);

        // single word, held until out_ready opens
        rdy_mode = 0;
        send_word(40'h80_0000_0001, 40'hFF_FFFF_FFFE, W, 1'b0);
        idle(3);
        rdy_mode = 1;
        idle(3);

        // back-to-back words with no gap
        for (int i = 0; i < 3; i++) send_word(rnd(), rnd(), W, 1'b0);
        idle(3);

        // short word, then a clean one
        send_word(rnd(), rnd(), 17, 1'b0);
        idle(2);
        send_word(rnd(), rnd(), W, 1'b0);
        idle(3);

        // flush landing on bit 20 with a word queued and a sticky flag set
        rdy_mode = 0;
        send_word(rnd(), rnd(), 5, 1'b0);
        idle(1);
        send_word(rnd(), rnd(), W, 1'b0);
        send_word(rnd(), rnd(), 20, 1'b0);
        flush = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        flush = 1'b0;
        send_word(rnd(), rnd(), W, 1'b0);
        idle(1);
        rdy_mode = 1;
        idle(4);

        // overflow: five words into four slots, then pop exactly on word 6 completion
        rdy_mode = 0;
        for (int i = 0; i < 5; i++) send_word(rnd(), rnd(), W, 1'b0);
        idle(1);
        send_word(rnd(), rnd(), W, 1'b1);
        idle(2);
        rdy_mode = 1;
        idle(8);

        // random lengths, gaps and consumer
        rdy_mode = 2;
        for (int i = 0; i < 25; i++) begin
            send_word(rnd(), rnd(), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 39)) : W, 1'b0);
            idle(int'($urandom_range(0, 2)));
        end
        rdy_mode = 1;
        idle(10);

        // 300 short words push the drop counter into saturation
        for (int i = 0; i < 300; i++) begin
            send_word(rnd(), rnd(), int'($urandom_range(1, 6)), 1'b0);
            drive(1'b0, 1'b0, 1'b0);
        end
        idle(3);
        chk("dropped_saturated", 80'(dropped_count), 80'(SAT));

        @(negedge SCLK);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
